// File: rtl/counter_pkg.sv
// Shared constants for the cascaded counter and its on-line checker.
package counter_pkg;

    localparam logic [1:0] MODO_UP    = 2'b00;
    localparam logic [1:0] MODO_DOWN  = 2'b01;
    localparam logic [1:0] MODO_DOWN3 = 2'b10;
    localparam logic [1:0] MODO_LOAD  = 2'b11;

    localparam int STEP3 = 3;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        TRACK  = 2'd2
    } chk_state_t;

endpackage

// File: rtl/counter_model.sv
// Pure next-state function of the counter contract: (q, enb, modo, d) -> (next_q, next_rco).
module counter_model
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur_q,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             next_rco
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STEP3);

    // rco flags the update that wrapped; a load never wraps.
    always_comb begin
        next_q   = cur_q;
        next_rco = 1'b0;
        if (enb) begin
            case (modo)
                MODO_UP: begin
                    next_q   = cur_q + 1'b1;
                    next_rco = &cur_q;
                end
                MODO_DOWN: begin
                    next_q   = cur_q - 1'b1;
                    next_rco = (cur_q == '0);
                end
                MODO_DOWN3: begin
                    next_q   = cur_q - STEP;
                    next_rco = (cur_q < STEP);
                end
                default: begin
                    next_q   = d;
                    next_rco = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_checker.sv
// On-line checker: tracks the counter with a reference model, flags Q/rco mismatches,
// counts them (saturating) and captures the first failure.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             rco,
    output logic             synced,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_q,
    output logic [WIDTH-1:0] first_exp,
    output logic [1:0]       first_modo
);

    chk_state_t       state;
    logic [WIDTH-1:0] exp_q;
    logic             exp_rco;
    logic [1:0]       pred_modo;
    logic [WIDTH-1:0] next_q;
    logic             next_rco;
    logic             mismatch;

    counter_model #(.WIDTH(WIDTH)) u_model (
        .cur_q    (exp_q),
        .enb      (enb),
        .modo     (modo),
        .d        (D),
        .next_q   (next_q),
        .next_rco (next_rco)
    );

    // Compare against the prediction made at the previous edge, before advancing it.
    assign mismatch = (state == TRACK) && ((Q != exp_q) || (rco != exp_rco));

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= UNSYNC;
            exp_q      <= '0;
            exp_rco    <= 1'b0;
            pred_modo  <= 2'b00;
            synced     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            first_q    <= '0;
            first_exp  <= '0;
            first_modo <= 2'b00;
        end else begin
            err       <= mismatch;
            pred_modo <= modo;
            case (state)
                UNSYNC: begin
                    if (enb && (modo == MODO_LOAD)) begin
                        exp_q   <= D;
                        exp_rco <= 1'b0;
                        synced  <= 1'b1;
                        state   <= SYNC;
                    end
                end
                SYNC: begin
                    exp_q   <= next_q;
                    exp_rco <= next_rco;
                    state   <= TRACK;
                end
                TRACK: begin
                    exp_q   <= next_q;
                    exp_rco <= next_rco;
                    if (mismatch) begin
                        // Only the first failure since reset is kept.
                        if (err_count == '0) begin
                            first_q    <= Q;
                            first_exp  <= exp_q;
                            first_modo <= pred_modo;
                        end
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= UNSYNC;
                    synced <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a behavioural counter drives Q/rco (with injectable slips)
// and an arithmetic reference of the checker predicts every output each cycle.
module tb_counter_checker;

    localparam int W     = 16;
    localparam int ERR_W = 8;
    localparam int MOD   = 1 << W;
    localparam int CNT_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             reset_L;
    logic             enb;
    logic [1:0]       modo;
    logic [W-1:0]     D;
    logic [W-1:0]     Q;
    logic             rco;
    logic             synced;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     first_q;
    logic [W-1:0]     first_exp;
    logic [1:0]       first_modo;

    int checks = 0;
    int errors = 0;

    // bench counter (stand-in for the real counter)
    int cnt_q   = 0;
    bit cnt_rco = 0;

    // reference of checker behaviour
    bit m_synced   = 0;
    bit m_tracking = 0;
    int m_exp      = 0;
    bit m_exp_rco  = 0;
    int m_prev_modo = 0;
    bit m_err      = 0;
    int m_cnt      = 0;
    int m_first_q  = 0;
    int m_first_exp = 0;
    int m_first_modo = 0;

    counter_checker #(.WIDTH(W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enb        (enb),
        .modo       (modo),
        .D          (D),
        .Q          (Q),
        .rco        (rco),
        .synced     (synced),
        .err        (err),
        .err_count  (err_count),
        .first_q    (first_q),
        .first_exp  (first_exp),
        .first_modo (first_modo)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Counter contract expressed as plain integer arithmetic.
    function automatic void ref_step(input int q, input bit e, input int m, input int d,
                                     output int nq, output bit nr);
        int t;
        nq = q;
        nr = 1'b0;
        if (e) begin
            case (m)
                0:       t = q + 1;
                1:       t = q - 1;
                2:       t = q - 3;
                default: t = d;
            endcase
            if (m != 3) nr = (t < 0) || (t >= MOD);
            nq = ((t % MOD) + MOD) % MOD;
        end
    endfunction

    task automatic model_edge(input bit rst_n, input bit e, input int m, input int d,
                              input int q_seen, input bit rco_seen);
        int nq;
        bit nr;
        bit bad;
        if (!rst_n) begin
            m_synced = 0; m_tracking = 0; m_exp = 0; m_exp_rco = 0; m_prev_modo = 0;
            m_err = 0; m_cnt = 0; m_first_q = 0; m_first_exp = 0; m_first_modo = 0;
            return;
        end
        ref_step(m_exp, e, m, d, nq, nr);
        m_err = 0;
        if (!m_synced) begin
            if (e && m == 3) begin
                m_synced  = 1;
                m_exp     = d;
                m_exp_rco = 0;
            end
        end else if (!m_tracking) begin
            m_tracking = 1;
            m_exp = nq;
            m_exp_rco = nr;
        end else begin
            bad = (q_seen != m_exp) || (rco_seen != m_exp_rco);
            m_err = bad;
            if (bad) begin
                if (m_cnt == 0) begin
                    m_first_q    = q_seen;
                    m_first_exp  = m_exp;
                    m_first_modo = m_prev_modo;
                end
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
            m_exp = nq;
            m_exp_rco = nr;
        end
        m_prev_modo = m;
    endtask

    task automatic check_all();
        check("synced",     32'(synced),     32'(m_synced));
        check("err",        32'(err),        32'(m_err));
        check("err_count",  32'(err_count),  32'(m_cnt));
        check("first_q",    32'(first_q),    32'(m_first_q));
        check("first_exp",  32'(first_exp),  32'(m_first_exp));
        check("first_modo", 32'(first_modo), 32'(m_first_modo));
    endtask

    // driver: one clock cycle; slip makes the counter jump by one before the edge
    task automatic tick(input bit rst_n, input bit e, input int m, input int d, input bit slip);
        int nq;
        bit nr;
        @(negedge clk);
        reset_L = rst_n;
        enb     = e;
        modo    = m[1:0];
        D       = d[W-1:0];
        if (slip) begin
            cnt_q = (cnt_q + 1) % MOD;
            Q     = cnt_q[W-1:0];
        end
        @(posedge clk);
        #1;
        model_edge(rst_n, e, m, d, cnt_q, cnt_rco);
        if (!rst_n) begin
            nq = 0;
            nr = 0;
        end else begin
            ref_step(cnt_q, e, m, d, nq, nr);
        end
        cnt_q   = nq;
        cnt_rco = nr;
        Q       = cnt_q[W-1:0];
        rco     = cnt_rco;
        check_all();
    endtask

    initial begin
        reset_L = 1'b0;
        enb     = 1'b0;
        modo    = 2'b00;
        D       = '0;
        Q       = '0;
        rco     = 1'b0;

        // reset and initial sync
        repeat (2) tick(0, 0, 0, 0, 0);
        check("reset_synced", 32'(synced), 32'd0);
        check("reset_count",  32'(err_count), 32'd0);
        tick(1, 1, 3, 16'h0000, 0);
        check("synced_after_load", 32'(synced), 32'd1);
        repeat (70) tick(1, 1, 0, 0, 0);

        // wrap up, wrap down by 3
        tick(1, 1, 3, 16'hFFFF, 0);
        repeat (2) tick(1, 1, 0, 0, 0);
        tick(1, 1, 3, 16'h0002, 0);
        repeat (2) tick(1, 1, 2, 0, 0);
        check("no_err_yet", 32'(err_count), 32'd0);

        // single slip: counter shows 5 where 4 is predicted
        tick(1, 1, 3, 16'h0003, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 1);
        check("slip_err",       32'(err), 32'd1);
        check("slip_count",     32'(err_count), 32'd1);
        check("slip_first_q",   32'(first_q), 32'h5);
        check("slip_first_exp", 32'(first_exp), 32'h4);
        check("slip_first_modo", 32'(first_modo), 32'd0);

        // persistent error stream saturates the counter
        repeat (300) tick(1, 1, 0, 0, 0);
        check("saturated", 32'(err_count), 32'hFF);
        check("first_q_kept", 32'(first_q), 32'h5);
        tick(0, 1, 0, 0, 0);
        check("midrun_reset_count", 32'(err_count), 32'd0);
        check("midrun_reset_synced", 32'(synced), 32'd0);

        // hold with enb=0 while modo cycles
        tick(1, 1, 3, 16'h0100, 0);
        repeat (3) tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, i % 3, 0, 0);
        repeat (3) tick(1, 1, 0, 0, 0);
        check("hold_no_err", 32'(err_count), 32'd0);

        // load coinciding with a slip
        tick(1, 1, 0, 0, 1);
        tick(1, 1, 3, 16'h1234, 1);
        repeat (2) tick(1, 1, 1, 0, 0);

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, MOD - 1)),
                 ($urandom_range(0, 24) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
